// File: rtl/im_pkg.sv
// -----------------------------------------------------------------------------
// im_pkg
// Shared definitions for the IM (memory-access) pipeline stage:
//   - access-size encodings (SZ_WORD / SZ_HALF / SZ_BYTE; 2'b11 behaves as word)
//   - FSM state enumeration (IDLE / REQ)
//   - helpers: lane offset normalisation, byte-enable lookup, misalignment test
// Memory is big-endian: byte offset 0 is data bits [31:24].
// -----------------------------------------------------------------------------
package im_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } im_state_e;

  // Byte offset actually used for lane selection: halves are forced to an
  // even offset and words to offset 0, so a misaligned access never straddles
  // a word.
  function automatic logic [1:0] align_offset(input logic [1:0] size,
                                              input logic [1:0] addr_lo);
    logic [1:0] off;
    case (size)
      SZ_BYTE: off = addr_lo;
      SZ_HALF: off = {addr_lo[1], 1'b0};
      default: off = 2'b00;
    endcase
    return off;
  endfunction

  // Byte enables, bit 3 = bits [31:24] (offset 0).
  function automatic logic [3:0] byte_en(input logic [1:0] size,
                                         input logic [1:0] off);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b1000 >> off;
      SZ_HALF: be = off[1] ? 4'b0011 : 4'b1100;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // True for a half at an odd address or a word not on a 4-byte boundary.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = addr_lo[0];
      default: mis = (addr_lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/im_stage_if.sv
// -----------------------------------------------------------------------------
// im_stage_if
// Data-memory request/acknowledge port of the IM stage.
//   mem_req   request active            mem_we    write strobe
//   mem_addr  word-aligned address      mem_wdata lane-replicated store data
//   mem_be    byte enables (bit 3 = [31:24])
//   mem_ack   transaction done, mem_rdata valid in the same cycle
// master: the IM stage; slave: the memory.
// -----------------------------------------------------------------------------
interface im_stage_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/im_load_align.sv
// -----------------------------------------------------------------------------
// im_load_align
// Combinational load-data alignment: picks the addressed byte/half lane of a
// big-endian word and sign- or zero-extends it to 32 bits.
//   i_rdata  read data          i_offset  normalised byte offset
//   i_size   access size        i_sign    1 sign-extend, 0 zero-extend
//   o_data   aligned, extended result
// -----------------------------------------------------------------------------
module im_load_align
  import im_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_offset,
  input  logic [1:0]  i_size,
  input  logic        i_sign,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane select (offset 0 is the most significant byte) and extension.
  always_comb begin
    w_byte = 8'h00;
    w_half = 16'h0000;
    o_data = i_rdata;
    case (i_offset)
      2'd0:    w_byte = i_rdata[31:24];
      2'd1:    w_byte = i_rdata[23:16];
      2'd2:    w_byte = i_rdata[15:8];
      default: w_byte = i_rdata[7:0];
    endcase
    if (i_offset[1]) begin
      w_half = i_rdata[15:0];
    end else begin
      w_half = i_rdata[31:16];
    end
    case (i_size)
      SZ_BYTE: o_data = {{24{i_sign & w_byte[7]}}, w_byte};
      SZ_HALF: o_data = {{16{i_sign & w_half[15]}}, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/im_stage.sv
// -----------------------------------------------------------------------------
// im_stage
// Memory-access stage. Non-memory instructions retire one cycle after
// acceptance; memory instructions run a req/ack transaction on `mem`, stalling
// upstream while in REQ, and retire on the ack edge. A transaction without ack
// for TIMEOUT_CYCLES REQ cycles is abandoned with a one-cycle bus_err pulse.
// Ports:
//   clk, rst_n (async active-low)
//   valid_in, pc_in, O_in, B_in, access_size_in, rw_in, mem_en_in,
//   memory_sign_extend_in, res_data_sel_in, rd_in : IX/IM register fields
//   stall                                         : hold upstream (state==REQ)
//   mem (im_stage_if.master)                      : data-memory port
//   wb_valid, wb_pc, wb_data, wb_rd               : registered writeback bundle
//   bus_err                                       : timeout pulse
//   misalign_err                                  : IM_MISALIGN_TRAP_EN only
// Configuration macro IM_MISALIGN_TRAP_EN: misaligned half/word accesses are
// trapped (misalign_err pulse, no transaction) instead of being forced aligned.
// -----------------------------------------------------------------------------
module im_stage
  import im_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] O_in,
  input  logic [31:0] B_in,
  input  logic [1:0]  access_size_in,
  input  logic        rw_in,
  input  logic        mem_en_in,
  input  logic        memory_sign_extend_in,
  input  logic        res_data_sel_in,
  input  logic [4:0]  rd_in,
  output logic        stall,
  im_stage_if.master  mem,
  output logic        wb_valid,
  output logic [31:0] wb_pc,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        bus_err
`ifdef IM_MISALIGN_TRAP_EN
 ,output logic        misalign_err
`endif
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  im_state_e        r_state;
  im_state_e        w_next;
  logic [CNT_W-1:0] r_cnt;

  // Fields latched at acceptance of a memory instruction.
  logic [31:0] r_pc;
  logic [31:0] r_o;
  logic [31:0] r_b;
  logic [1:0]  r_size;
  logic        r_rw;
  logic        r_sign;
  logic        r_sel;
  logic [4:0]  r_rd;

  logic        w_accept;
  logic        w_retire_alu;
  logic        w_retire_mem;
  logic        w_timeout;
  logic        w_misalign;
  logic        w_in_req;
  logic [1:0]  w_off;
  logic [31:0] w_load;
  logic [31:0] w_wdata;

  assign w_in_req = (r_state == ST_REQ);
  assign w_off    = align_offset(r_size, r_o[1:0]);

  im_load_align u_load_align (
    .i_rdata  (mem.mem_rdata),
    .i_offset (w_off),
    .i_size   (r_size),
    .i_sign   (r_sign),
    .o_data   (w_load)
  );

  // Store data replicated across every lane it may be written to.
  always_comb begin
    case (r_size)
      SZ_BYTE: w_wdata = {4{r_b[7:0]}};
      SZ_HALF: w_wdata = {2{r_b[15:0]}};
      default: w_wdata = r_b;
    endcase
  end

  // Memory port is driven from registered state only and is quiet in IDLE;
  // the async reset of r_state drops mem_req without waiting for an edge.
  assign stall         = w_in_req;
  assign mem.mem_req   = w_in_req;
  assign mem.mem_we    = w_in_req & r_rw;
  assign mem.mem_addr  = w_in_req ? {r_o[31:2], 2'b00} : 32'h0000_0000;
  assign mem.mem_be    = w_in_req ? byte_en(r_size, w_off) : 4'b0000;
  assign mem.mem_wdata = w_in_req ? w_wdata : 32'h0000_0000;

  // Next-state and per-cycle event decode.
  always_comb begin
    w_next       = r_state;
    w_accept     = 1'b0;
    w_retire_alu = 1'b0;
    w_retire_mem = 1'b0;
    w_timeout    = 1'b0;
    w_misalign   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (valid_in && !mem_en_in) begin
          w_retire_alu = 1'b1;
        end else if (valid_in) begin
`ifdef IM_MISALIGN_TRAP_EN
          if (is_misaligned(access_size_in, O_in[1:0])) begin
            w_misalign = 1'b1;
          end else begin
            w_accept = 1'b1;
            w_next   = ST_REQ;
          end
`else
          w_accept = 1'b1;
          w_next   = ST_REQ;
`endif
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_REQ: begin
        // An ack in the last allowed cycle still wins over the timeout.
        if (mem.mem_ack) begin
          w_retire_mem = 1'b1;
          w_next       = ST_IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_timeout = 1'b1;
          w_next    = ST_IDLE;
        end else begin
          w_next = ST_REQ;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // REQ-cycle counter: 0 in the first REQ cycle, +1 per cycle without ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
    end else if (w_in_req) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Latch the instruction fields at acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc   <= 32'h0000_0000;
      r_o    <= 32'h0000_0000;
      r_b    <= 32'h0000_0000;
      r_size <= 2'b00;
      r_rw   <= 1'b0;
      r_sign <= 1'b0;
      r_sel  <= 1'b0;
      r_rd   <= 5'd0;
    end else if (w_accept) begin
      r_pc   <= pc_in;
      r_o    <= O_in;
      r_b    <= B_in;
      r_size <= access_size_in;
      r_rw   <= rw_in;
      r_sign <= memory_sign_extend_in;
      r_sel  <= res_data_sel_in;
      r_rd   <= rd_in;
    end else begin
      r_pc   <= r_pc;
      r_o    <= r_o;
      r_b    <= r_b;
      r_size <= r_size;
      r_rw   <= r_rw;
      r_sign <= r_sign;
      r_sel  <= r_sel;
      r_rd   <= r_rd;
    end
  end

  // Writeback bundle and error pulses; the bundle holds between retirements.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid <= 1'b0;
      wb_pc    <= 32'h0000_0000;
      wb_data  <= 32'h0000_0000;
      wb_rd    <= 5'd0;
      bus_err  <= 1'b0;
    end else begin
      wb_valid <= w_retire_alu | w_retire_mem;
      bus_err  <= w_timeout;
      if (w_retire_alu) begin
        wb_pc   <= pc_in;
        wb_data <= O_in;
        wb_rd   <= rd_in;
      end else if (w_retire_mem) begin
        // Stores always write back the address/ALU result.
        wb_pc   <= r_pc;
        wb_data <= (r_sel && !r_rw) ? w_load : r_o;
        wb_rd   <= r_rd;
      end else begin
        wb_pc   <= wb_pc;
        wb_data <= wb_data;
        wb_rd   <= wb_rd;
      end
    end
  end

`ifdef IM_MISALIGN_TRAP_EN
  // Misalignment trap pulse at the edge that would have accepted the access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= w_misalign;
    end
  end
`else
  logic w_unused_misalign;
  assign w_unused_misalign = w_misalign;
`endif

endmodule

// File: tb/tb_im_stage.sv
// Self-checking bench for im_stage: directed test-plan steps followed by a
// randomized instruction stream checked against a behavioural model.
module tb_im_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in;
  logic [31:0] pc_in, O_in, B_in;
  logic [1:0]  access_size_in;
  logic        rw_in, mem_en_in, memory_sign_extend_in, res_data_sel_in;
  logic [4:0]  rd_in;
  logic        stall;
  logic        wb_valid;
  logic [31:0] wb_pc, wb_data;
  logic [4:0]  wb_rd;
  logic        bus_err;
`ifdef IM_MISALIGN_TRAP_EN
  logic        misalign_err;
`endif

  int n_checks = 0;
  int n_errors = 0;

  im_stage_if mem_if ();

  im_stage #(.TIMEOUT_CYCLES(16)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .valid_in              (valid_in),
    .pc_in                 (pc_in),
    .O_in                  (O_in),
    .B_in                  (B_in),
    .access_size_in        (access_size_in),
    .rw_in                 (rw_in),
    .mem_en_in             (mem_en_in),
    .memory_sign_extend_in (memory_sign_extend_in),
    .res_data_sel_in       (res_data_sel_in),
    .rd_in                 (rd_in),
    .stall                 (stall),
    .mem                   (mem_if.master),
    .wb_valid              (wb_valid),
    .wb_pc                 (wb_pc),
    .wb_data               (wb_data),
    .wb_rd                 (wb_rd),
    .bus_err               (bus_err)
`ifdef IM_MISALIGN_TRAP_EN
   ,.misalign_err          (misalign_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  function automatic int m_off(input logic [1:0] sz, input logic [31:0] a);
    int lo;
    lo = int'(a % 4);
    if (sz == 2'b10) return lo;
    if (sz == 2'b01) return (lo / 2) * 2;
    return 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] sz, input int off);
    if (sz == 2'b10) return 4'(1 << (3 - off));
    if (sz == 2'b01) return 4'(3 << (2 - off));
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] b);
    if (sz == 2'b10) return {24'h0, b[7:0]} * 32'h0101_0101;
    if (sz == 2'b01) return {16'h0, b[15:0]} * 32'h0001_0001;
    return b;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input int off,
                                         input logic sgn, input logic [31:0] rd);
    logic [31:0] v;
    if (sz == 2'b10) begin
      v = (rd >> (8 * (3 - off))) & 32'hFF;
      if (sgn && v >= 32'd128) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'b01) begin
      v = (rd >> (8 * (2 - off))) & 32'hFFFF;
      if (sgn && v >= 32'd32768) v = v | 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  function automatic logic m_mis(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'b10) return 1'b0;
    if (sz == 2'b01) return (a % 2) != 0;
    return (a % 4) != 0;
  endfunction

  // Non-memory instruction: retires at the next edge with O.
  task automatic do_alu(input logic [31:0] pc, input logic [31:0] o, input logic [4:0] rd);
    valid_in = 1'b1; mem_en_in = 1'b0; pc_in = pc; O_in = o; rd_in = rd;
    B_in = $urandom; access_size_in = 2'($urandom); rw_in = 1'($urandom);
    res_data_sel_in = 1'($urandom); memory_sign_extend_in = 1'($urandom);
    chk("alu/stall_before", {31'b0, stall}, 32'd0);
    tick();
    valid_in = 1'b0;
    chk("alu/wb_valid", {31'b0, wb_valid}, 32'd1);
    chk("alu/wb_data", wb_data, o);
    chk("alu/wb_rd", {27'b0, wb_rd}, {27'b0, rd});
    chk("alu/wb_pc", wb_pc, pc);
    chk("alu/stall_after", {31'b0, stall}, 32'd0);
  endtask

  // Memory instruction; ack in REQ cycle ack_cyc (0 = never -> timeout).
  task automatic do_mem(input string tag, input logic [31:0] pc, input logic [31:0] o,
                        input logic [31:0] b, input logic [1:0] sz, input logic rw,
                        input logic sgn, input logic sel, input logic [4:0] rd,
                        input int ack_cyc, input logic [31:0] rdata);
    int off;
    logic trap;
    logic [31:0] exp_wb;
    off = m_off(sz, o);
    trap = 1'b0;
`ifdef IM_MISALIGN_TRAP_EN
    trap = m_mis(sz, o);
`endif
    exp_wb = (sel && !rw) ? m_load(sz, off, sgn, rdata) : o;
    valid_in = 1'b1; mem_en_in = 1'b1; pc_in = pc; O_in = o; B_in = b;
    access_size_in = sz; rw_in = rw; memory_sign_extend_in = sgn;
    res_data_sel_in = sel; rd_in = rd;
    chk({tag, "/stall_idle"}, {31'b0, stall}, 32'd0);
    tick();
    if (trap) begin
      valid_in = 1'b0;
`ifdef IM_MISALIGN_TRAP_EN
      chk({tag, "/misalign_err"}, {31'b0, misalign_err}, 32'd1);
`endif
      chk({tag, "/trap_req"}, {31'b0, mem_if.mem_req}, 32'd0);
      chk({tag, "/trap_wb_valid"}, {31'b0, wb_valid}, 32'd0);
      tick();
`ifdef IM_MISALIGN_TRAP_EN
      chk({tag, "/misalign_pulse"}, {31'b0, misalign_err}, 32'd0);
`endif
      return;
    end
    // Inputs change while in REQ; the stage must use its latched copy.
    valid_in = 1'($urandom); O_in = $urandom; B_in = $urandom;
    for (int c = 1; c <= 16; c++) begin
      chk({tag, "/stall"}, {31'b0, stall}, 32'd1);
      chk({tag, "/req"}, {31'b0, mem_if.mem_req}, 32'd1);
      chk({tag, "/wb_valid_req"}, {31'b0, wb_valid}, 32'd0);
      if (c == 1) begin
        chk({tag, "/we"}, {31'b0, mem_if.mem_we}, {31'b0, rw});
        chk({tag, "/addr"}, mem_if.mem_addr, o - (o % 4));
        chk({tag, "/be"}, {28'b0, mem_if.mem_be}, {28'b0, m_be(sz, off)});
        if (rw) chk({tag, "/wdata"}, mem_if.mem_wdata, m_wdata(sz, b));
      end
      if (c == ack_cyc) begin
        mem_if.mem_ack = 1'b1; mem_if.mem_rdata = rdata;
      end else begin
        mem_if.mem_ack = 1'b0; mem_if.mem_rdata = $urandom;
      end
      tick();
      if (c == ack_cyc) begin
        mem_if.mem_ack = 1'b0; valid_in = 1'b0;
        chk({tag, "/wb_valid"}, {31'b0, wb_valid}, 32'd1);
        chk({tag, "/wb_data"}, wb_data, exp_wb);
        chk({tag, "/wb_rd"}, {27'b0, wb_rd}, {27'b0, rd});
        chk({tag, "/wb_pc"}, wb_pc, pc);
        chk({tag, "/bus_err_ack"}, {31'b0, bus_err}, 32'd0);
        chk({tag, "/stall_done"}, {31'b0, stall}, 32'd0);
        break;
      end else if (c == 16) begin
        valid_in = 1'b0;
        chk({tag, "/bus_err"}, {31'b0, bus_err}, 32'd1);
        chk({tag, "/to_wb_valid"}, {31'b0, wb_valid}, 32'd0);
        chk({tag, "/to_idle"}, {31'b0, stall}, 32'd0);
        chk({tag, "/to_req"}, {31'b0, mem_if.mem_req}, 32'd0);
        tick();
        chk({tag, "/bus_err_pulse"}, {31'b0, bus_err}, 32'd0);
        chk({tag, "/to_no_wb"}, {31'b0, wb_valid}, 32'd0);
      end else begin
        chk({tag, "/bus_err_req"}, {31'b0, bus_err}, 32'd0);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; valid_in = 1'b0; pc_in = '0; O_in = '0; B_in = '0;
    access_size_in = 2'b00; rw_in = 1'b0; mem_en_in = 1'b0;
    memory_sign_extend_in = 1'b0; res_data_sel_in = 1'b0; rd_in = 5'd0;
    mem_if.mem_ack = 1'b0; mem_if.mem_rdata = 32'h0;
    #1;
    chk("rst/wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("rst/wb_data", wb_data, 32'd0);
    chk("rst/wb_pc", wb_pc, 32'd0);
    chk("rst/wb_rd", {27'b0, wb_rd}, 32'd0);
    chk("rst/bus_err", {31'b0, bus_err}, 32'd0);
    chk("rst/stall", {31'b0, stall}, 32'd0);
    chk("rst/req", {31'b0, mem_if.mem_req}, 32'd0);
    chk("rst/be", {28'b0, mem_if.mem_be}, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // ALU op, then an idle cycle: wb_valid is a single pulse.
    do_alu(32'h0000_1000, 32'h0000_0042, 5'd5);
    tick();
    chk("alu/wb_pulse", {31'b0, wb_valid}, 32'd0);

    // lb / lbu at 0x103, ack in REQ cycle 1.
    do_mem("lb", 32'h1004, 32'h103, 32'h0, 2'b10, 1'b0, 1'b1, 1'b1, 5'd7, 1, 32'h1122_3380);
    chk("lb/value", wb_data, 32'hFFFF_FF80);
    do_mem("lbu", 32'h1008, 32'h103, 32'h0, 2'b10, 1'b0, 1'b0, 1'b1, 5'd8, 1, 32'h1122_3380);
    chk("lbu/value", wb_data, 32'h0000_0080);

    // sh at 0x102.
    do_mem("sh", 32'h100C, 32'h102, 32'h0000_BEEF, 2'b01, 1'b1, 1'b0, 1'b0, 5'd0, 2, 32'h0);

    // lw at 0x200, ack in cycle 4, second lw right after (one bubble).
    do_mem("lw4", 32'h1010, 32'h200, 32'h0, 2'b00, 1'b0, 1'b0, 1'b1, 5'd9, 4, 32'hCAFE_F00D);
    do_mem("lw_b2b", 32'h1014, 32'h204, 32'h0, 2'b00, 1'b0, 1'b0, 1'b1, 5'd10, 1, 32'h1234_5678);
    chk("lw_b2b/value", wb_data, 32'h1234_5678);

    // Timeout: no ack for 16 REQ cycles.
    do_mem("timeout", 32'h1018, 32'h300, 32'h0, 2'b00, 1'b0, 1'b0, 1'b1, 5'd11, 0, 32'h0);
    // Ack in the last allowed cycle beats the timeout.
    do_mem("ack16", 32'h101C, 32'h304, 32'h0, 2'b00, 1'b0, 1'b0, 1'b1, 5'd12, 16, 32'h0BAD_CAFE);

    // lw at 0x201: trapped with the macro, forced aligned without it.
    do_mem("lw201", 32'h1020, 32'h201, 32'h0, 2'b00, 1'b0, 1'b0, 1'b1, 5'd13, 1, 32'h5555_AAAA);

    // Reset in REQ cycle 2 drops mem_req without a clock edge.
    valid_in = 1'b1; mem_en_in = 1'b1; O_in = 32'h400; access_size_in = 2'b00;
    rw_in = 1'b0; res_data_sel_in = 1'b1; rd_in = 5'd14; pc_in = 32'h1024;
    tick();
    valid_in = 1'b0;
    tick();
    chk("rstreq/req_before", {31'b0, mem_if.mem_req}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstreq/req_async", {31'b0, mem_if.mem_req}, 32'd0);
    chk("rstreq/stall_async", {31'b0, stall}, 32'd0);
    tick();
    rst_n = 1'b1;
    mem_if.mem_ack = 1'b1;
    tick();
    mem_if.mem_ack = 1'b0;
    chk("rstreq/no_wb", {31'b0, wb_valid}, 32'd0);
    chk("rstreq/idle", {31'b0, mem_if.mem_req}, 32'd0);

    // Randomized instruction stream.
    for (int i = 0; i < 40; i++) begin
      int kind;
      int ack;
      kind = $urandom_range(0, 2);
      ack = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 5);
      if (kind == 0) begin
        do_alu($urandom, $urandom, 5'($urandom));
      end else begin
        do_mem("rnd", $urandom, $urandom, $urandom, 2'($urandom), (kind == 2),
               1'($urandom), 1'($urandom), 5'($urandom), ack, $urandom);
      end
      if ($urandom_range(0, 1) == 1) begin
        valid_in = 1'b0;
        tick();
        chk("rnd/idle_wb", {31'b0, wb_valid}, 32'd0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/im_stage.md
# im_stage

Memory-access (IM) stage of the five-stage pipeline, directly downstream of the IX/IM pipeline register. It consumes the latched ALU result/address, store data and memory-control fields, and runs a request/acknowledge transaction on the data-memory port. For sub-word loads it aligns and sign- or zero-extends the returned data. It presents a registered writeback bundle to the IM/WB boundary and stalls the upstream pipeline while a transaction is outstanding.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16: number of REQ cycles without `mem_ack` before the transaction is abandoned.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- valid_in  in  1  the IX/IM fields hold a live instruction
- pc_in  in  32  instruction PC
- O_in  in  32  ALU result / effective address
- B_in  in  32  store data
- access_size_in  in  2  00 word, 01 halfword, 10 byte, 11 treated as word
- rw_in  in  1  1 store, 0 load
- mem_en_in  in  1  instruction accesses memory
- memory_sign_extend_in  in  1  1 sign-extend sub-word load, 0 zero-extend
- res_data_sel_in  in  1  1 writeback takes load data, 0 takes O
- rd_in  in  5  destination register
- stall  out  1  hold the upstream pipeline
- mem_req, mem_we  out  1  request; write strobe
- mem_addr  out  32  word-aligned address
- mem_wdata  out  32  lane-replicated store data
- mem_be  out  4  byte enables, bit 3 = bits [31:24]
- mem_ack  in  1  transaction complete; rdata valid the same cycle
- mem_rdata  in  32  read data
- wb_valid  out  1  writeback bundle valid, one-cycle pulse per retired instruction
- wb_pc, wb_data  out  32  retired PC; result
- wb_rd  out  5  destination register
- bus_err  out  1  one-cycle pulse on timeout
- misalign_err  out  1  one-cycle pulse; present only under the configuration macro

## Operation
- Memory is big-endian: address offset 0 maps to bits [31:24].
- FSM states are IDLE and REQ.
- IDLE, `valid_in`=1, `mem_en_in`=0: at the next edge `wb_valid`=1, `wb_data`=`O_in`, `wb_rd`=`rd_in`, `wb_pc`=`pc_in`.
- IDLE, `valid_in`=1, `mem_en_in`=1: latch all fields, clear the timeout counter, go to REQ. `wb_valid`=0.
- IDLE, `valid_in`=0: `wb_valid`=0.
- REQ outputs:
  - `mem_req`=1, `mem_we`=latched rw, `mem_addr`={O[31:2],2'b00}.
  - Byte enables: word 1111; half at offset 0 → 1100, at offset 2 → 0011; byte → 1000>>O[1:0].
  - `mem_wdata`: byte replicated ×4, half replicated ×2.
- REQ, `mem_ack`=1: go to IDLE and at that edge `wb_valid`=1.
  - `wb_data` = extended load lane if latched `res_data_sel`=1, else latched O. A store writes back O.
- REQ, no ack:
  - The counter increments each cycle.
  - When the counter reaches TIMEOUT_CYCLES−1 with no ack: go to IDLE, `bus_err`=1 for one cycle, `wb_valid`=0.
  - An ack in that same cycle wins over the timeout.
- `valid_in` is ignored in REQ.
- `stall` = (state==REQ), combinational. It is high during the ack cycle as well.

## Timing
- Reset: state IDLE, counter 0, and every output register 0 (`wb_*`, `bus_err`, `misalign_err`). `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `mem_be` and `stall` are 0 while in IDLE.
- Reset mid-REQ drops `mem_req` immediately and abandons the transaction with no writeback.
- Non-memory op: `wb_valid` one cycle after the accepting edge.
- Memory op with ack in cycle k of REQ (k≥1): `stall` high for k cycles; `wb_valid` on the edge ending REQ cycle k.
- Back-to-back memory ops: the second op is accepted in the first IDLE cycle after the ack, so there is one bubble cycle.

## Configuration
- `IM_MISALIGN_TRAP_EN` defined:
  - A half with O[0]=1, or a word with O[1:0]≠0, does not enter REQ.
  - `misalign_err` pulses at the accepting edge, `wb_valid`=0.
- Undefined:
  - The low address bits are forced aligned (half: O[0]=0; word: O[1:0]=0).
  - The `misalign_err` port is absent.

## Structure
- Package `im_pkg`:
  - access-size encodings (SZ_WORD, SZ_HALF, SZ_BYTE)
  - FSM state enum
  - a byte-enable lookup function
- Sub-module `im_load_align`: combinational lane select plus sign/zero extension from {rdata, offset, size, sign}.
- The FSM, counter and writeback registers live in `im_stage`.

## Test plan
- ALU op: O=0x0000_0042, rd=5, mem_en=0 → next cycle `wb_valid`=1, `wb_data`=0x42, `wb_rd`=5, `stall` never high.
- lb at 0x103, rdata 0x1122_3380, ack in REQ cycle 1 → `mem_be`=0001, `wb_data`=0xFFFF_FF80. Same access as lbu → 0x0000_0080.
- sh at 0x102, B=0x0000_BEEF → `mem_we`=1, `mem_addr`=0x100, `mem_be`=0011, `mem_wdata`=0xBEEF_BEEF.
- lw at 0x200, ack in REQ cycle 4 → `stall` high exactly 4 cycles, `wb_data`=rdata, and a second lw is accepted after one bubble.
- No ack, TIMEOUT_CYCLES=16 → after 16 REQ cycles `bus_err` pulses once, no `wb_valid`, FSM in IDLE. Separately, deassert `rst_n` in REQ cycle 2 → `mem_req` drops without waiting for a clock edge.
- With `IM_MISALIGN_TRAP_EN`: lw at 0x201 → `misalign_err` pulse, `mem_req` stays 0. Without the macro → `mem_addr`=0x200, `mem_be`=1111.
